// File: rtl/pcle_count_stage_if.sv
// pcle_count_stage_if: control, counter and wrap-event handshake bundle for pcle_count_stage
// Ports (slave = stage side):
//   in : load, load_val, cnt_en, cnt_inh, ev_ready, ovr_clr
//   out: count, tc, ev_valid, ev_seq, overrun
interface pcle_count_stage_if #(
  parameter int WIDTH = 8,
  parameter int SEQ_W = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             cnt_en;
  logic             cnt_inh;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ev_valid;
  logic             ev_ready;
  logic [SEQ_W-1:0] ev_seq;
  logic             overrun;
  logic             ovr_clr;
  modport master (
    output load, load_val, cnt_en, cnt_inh, ev_ready, ovr_clr,
    input  count, tc, ev_valid, ev_seq, overrun
  );
  modport slave (
    input  load, load_val, cnt_en, cnt_inh, ev_ready, ovr_clr,
    output count, tc, ev_valid, ev_seq, overrun
  );
endinterface

// File: rtl/pcle_count_stage.sv
// pcle_count_stage: loadable counter stage emitting sequenced terminal-count events through a 2-entry buffer
// Ports: clk, rst_n (async active-low), bus (pcle_count_stage_if.slave).
// Build option: define PCLE_SAT_EN for a saturating counter whose event fires on arrival at all-ones.
module pcle_count_stage #(
  parameter int WIDTH = 8,
  parameter int SEQ_W = 4
) (
  input logic               clk,
  input logic               rst_n,
  pcle_count_stage_if.slave bus
);
  localparam logic [WIDTH-1:0] ONES = '1;
  logic [WIDTH-1:0] count_q, count_d;
  logic [SEQ_W-1:0] seq_q, seq_d, e0_q, e0_d, e1_q, e1_d;
  logic [1:0]       occ_q, occ_d, wi;
  logic             ovr_q, ovr_d, inc, tc, pop, wr, drop;
  // e0 is the head entry; wi is the slot a new event lands in after any same-cycle pop
  always_comb begin
    inc = bus.cnt_en & ~bus.cnt_inh & ~bus.load;
`ifdef PCLE_SAT_EN
    tc = inc & (count_q == ONES - WIDTH'(1));
    count_d = bus.load ? bus.load_val : (inc && count_q != ONES) ? count_q + WIDTH'(1) : count_q;
`else
    tc = inc & (count_q == ONES);
    count_d = bus.load ? bus.load_val : inc ? count_q + WIDTH'(1) : count_q;
`endif
    seq_d = tc ? seq_q + SEQ_W'(1) : seq_q;
    pop = (occ_q != 2'd0) & bus.ev_ready;
    drop = tc & (occ_q == 2'd2) & ~pop;
    wr = tc & ~drop;
    wi = occ_q - {1'b0, pop};
    e0_d = (wr && wi == 2'd0) ? seq_d : pop ? e1_q : e0_q;
    e1_d = (wr && wi == 2'd1) ? seq_d : e1_q;
    occ_d = occ_q + {1'b0, wr} - {1'b0, pop};
    ovr_d = drop | (ovr_q & ~bus.ovr_clr);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      seq_q <= '0;
      e0_q <= '0;
      e1_q <= '0;
      occ_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      seq_q <= seq_d;
      e0_q <= e0_d;
      e1_q <= e1_d;
      occ_q <= occ_d;
      ovr_q <= ovr_d;
    end
  end
  assign bus.count = count_q;
  assign bus.tc = tc;
  assign bus.ev_valid = occ_q != 2'd0;
  assign bus.ev_seq = (occ_q != 2'd0) ? e0_q : '0;
  assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_pcle_count_stage.sv
// tb_pcle_count_stage: randomized and directed checks of pcle_count_stage against a queue-based model
module tb_pcle_count_stage;
`ifdef PCLE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int PRE = SAT ? 254 : 255;
  logic clk, rst_n;
  pcle_count_stage_if #(.WIDTH(8), .SEQ_W(4)) bus ();
  pcle_count_stage #(.WIDTH(8), .SEQ_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int errors = 0, checks = 0;
  int m_cnt, m_seq, m_ovr, last_tc;
  int q[$];
  bit run = 0;
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  function automatic int exp_tc();
    bit inc = bus.cnt_en && !bus.cnt_inh && !bus.load;
    return (inc && m_cnt == (SAT ? 254 : 255)) ? 1 : 0;
  endfunction
  task automatic model_step();
    int t = exp_tc();
    bit inc = bus.cnt_en && !bus.cnt_inh && !bus.load;
    bit drop = 0;
    if (q.size() > 0 && bus.ev_ready) void'(q.pop_front());
    if (t != 0) begin
      m_seq = (m_seq + 1) % 16;
      if (q.size() < 2) q.push_back(m_seq);
      else drop = 1;
    end
    m_ovr = drop ? 1 : bus.ovr_clr ? 0 : m_ovr;
    if (bus.load) m_cnt = int'(bus.load_val);
    else if (inc) m_cnt = SAT ? ((m_cnt == 255) ? 255 : m_cnt + 1) : (m_cnt + 1) % 256;
  endtask
  always @(negedge clk) if (run) begin
    chk("count", int'(bus.count), m_cnt);
    chk("tc", int'(bus.tc), exp_tc());
    chk("ev_valid", int'(bus.ev_valid), (q.size() > 0) ? 1 : 0);
    chk("ev_seq", int'(bus.ev_seq), (q.size() > 0) ? q[0] : 0);
    chk("overrun", int'(bus.overrun), m_ovr);
  end
  task automatic cyc(bit l, int lv, bit en, bit inh, bit rdy, bit clr);
    bus.load = l;
    bus.load_val = lv[7:0];
    bus.cnt_en = en;
    bus.cnt_inh = inh;
    bus.ev_ready = rdy;
    bus.ovr_clr = clr;
    #2 last_tc = int'(bus.tc);
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic do_reset();
    run = 0;
    rst_n = 0;
    #3;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_ev_valid", int'(bus.ev_valid), 0);
    chk("rst_ev_seq", int'(bus.ev_seq), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    m_cnt = 0;
    m_seq = 0;
    m_ovr = 0;
    q.delete();
    @(posedge clk);
    #1 rst_n = 1;
    run = 1;
  endtask
  task automatic wrap(bit rdy);
    cyc(1, PRE, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, rdy, 0);
  endtask
  initial begin
    int tcs;
    bus.load = 0;
    bus.load_val = '0;
    bus.cnt_en = 0;
    bus.cnt_inh = 0;
    bus.ev_ready = 0;
    bus.ovr_clr = 0;
    rst_n = 0;
    do_reset();
`ifdef PCLE_SAT_EN
    cyc(1, 8'hFE, 0, 0, 0, 0);
    tcs = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0, 0, 0);
      tcs += last_tc;
      chk("sat_count", int'(bus.count), 255);
    end
    chk("sat_tc_total", tcs, 1);
    chk("sat_ev_seq", int'(bus.ev_seq), 1);
    chk("sat_ev_valid", int'(bus.ev_valid), 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("sat_one_event", int'(bus.ev_valid), 0);
`else
    cyc(1, 8'hFD, 0, 0, 0, 0);
    chk("load_fd", int'(bus.count), 8'hFD);
    cyc(0, 0, 1, 0, 0, 0);
    chk("cnt_fe", int'(bus.count), 8'hFE);
    chk("tc_fd", last_tc, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("cnt_ff", int'(bus.count), 8'hFF);
    chk("tc_fe", last_tc, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("tc_ff", last_tc, 1);
    chk("cnt_00", int'(bus.count), 0);
    chk("wrap_valid", int'(bus.ev_valid), 1);
    chk("wrap_seq", int'(bus.ev_seq), 1);
`endif
    cyc(1, 8'hFF, 0, 0, 0, 0);
    cyc(1, 8'h10, 1, 0, 0, 0);
    chk("prio_tc", last_tc, 0);
    chk("prio_count", int'(bus.count), 8'h10);
    chk("prio_no_event", q.size(), SAT ? 0 : 1);
    cyc(0, 0, 1, 1, 0, 0);
    chk("inh_hold", int'(bus.count), 8'h10);
    wrap(0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("pre_rst_queued", int'(bus.ev_valid), 1);
    do_reset();
    wrap(0);
    wrap(0);
    wrap(0);
    chk("bp_overrun", int'(bus.overrun), 1);
    chk("bp_head1", int'(bus.ev_seq), 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("bp_head2", int'(bus.ev_seq), 2);
    cyc(0, 0, 0, 0, 1, 0);
    chk("bp_empty", int'(bus.ev_valid), 0);
    chk("bp_sticky", int'(bus.overrun), 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("bp_clr", int'(bus.overrun), 0);
    do_reset();
    wrap(0);
    wrap(0);
    wrap(1);
    chk("full_pp_head", int'(bus.ev_seq), 2);
    chk("full_pp_ovr", int'(bus.overrun), 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("full_pp_next", int'(bus.ev_seq), 3);
    wrap(0);
    cyc(1, PRE, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 1);
    chk("clr_vs_drop", int'(bus.overrun), 1);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 3);
      int lv = (r == 0) ? 253 : (r == 1) ? 254 : (r == 2) ? 255 : int'($urandom_range(0, 255));
      cyc($urandom_range(0, 7) == 0, lv, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end
    run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
